// File: rtl/ckdiv_pkg.sv
// Shared types and reset defaults for the fractional clock-enable divider.
package ckdiv_pkg;

  localparam int INC_RESET    = 1;
  localparam int MOD_RESET    = 1;
  localparam int MAX_CHANNELS = 16;
  localparam int CFG_WIDTH    = 32;

  // One pending configuration request held in the shadow slot.
  typedef struct packed {
    logic [3:0]           chan;
    logic [CFG_WIDTH-1:0] inc;
    logic [CFG_WIDTH-1:0] mod;
  } cfg_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_PENDING
  } slot_state_t;

endpackage

// File: rtl/ckdiv_chan.sv
// Single fractional accumulator channel: ticks inc times every mod cycles.
// A load replaces inc/mod and restarts the phase at 0; clear only restarts the phase.
module ckdiv_chan
  import ckdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             run,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_inc,
  input  logic [WIDTH-1:0] load_mod,
  output logic             ovf,
  output logic             tick
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] mod;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wrapped;

  // One extra bit on the sum keeps inc <= mod from ever overflowing.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, inc};
    wrapped = sum[WIDTH-1:0] - mod;
    ovf     = run && (sum >= {1'b0, mod});
  end

  // Accumulator update; a load lands on the overflow cycle so its tick survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      inc  <= WIDTH'(INC_RESET);
      mod  <= WIDTH'(MOD_RESET);
      tick <= 1'b0;
    end else if (en) begin
      if (load) begin
        inc  <= load_inc;
        mod  <= load_mod;
        acc  <= '0;
        tick <= ovf && !clear;
      end else if (clear) begin
        acc  <= '0;
        tick <= 1'b0;
      end else if (run) begin
        acc  <= ovf ? wrapped : sum[WIDTH-1:0];
        tick <= ovf;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ckdiv_ctrl.sv
// Multi-channel fractional clock-enable generator with a single shadow
// configuration slot. Define CKDIV_CTRL_SYNC_EN to make the sync pulse
// restart every channel's phase; otherwise sync is ignored.
//
// state        | meaning
// SLOT_EMPTY   | no request held, cfg_ready high
// SLOT_PENDING | request held until its channel can take it glitch-free
module ckdiv_ctrl
  import ckdiv_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_chan,
  input  logic [WIDTH-1:0]    cfg_inc,
  input  logic [WIDTH-1:0]    cfg_mod,
  output logic                cfg_err,
  input  logic [CHANNELS-1:0] run,
  input  logic                sync,
  output logic                busy,
  output logic [CHANNELS-1:0] ckena
);

  logic                en;
  slot_state_t         state;
  slot_state_t         state_next;
  cfg_t                shadow;
  logic                accept;
  logic                cfg_bad;
  logic                apply;
  logic                clear;
  logic [CHANNELS-1:0] ovf;
  logic [CHANNELS-1:0] load;

  assign cfg_ready = (state == SLOT_EMPTY);
  assign busy      = (state == SLOT_PENDING);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_mod == '0) || (cfg_inc > cfg_mod) ||
                     (32'(cfg_chan) >= 32'(CHANNELS));
  assign apply     = |load;

`ifdef CKDIV_CTRL_SYNC_EN
  assign clear = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign clear       = 1'b0;
`endif

  // Reset release is retimed here so the channels start on a clean edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) en <= 1'b0;
    else        en <= 1'b1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    // Stopped channels take the config at once; running ones wait for overflow.
    assign load[c] = busy && en && (shadow.chan == 4'(c)) && (!run[c] || ovf[c]);

    ckdiv_chan #(.WIDTH(WIDTH)) u_chan (
      .clock    (clock),
      .reset    (reset),
      .en       (en),
      .run      (run[c]),
      .load     (load[c]),
      .clear    (clear),
      .load_inc (shadow.inc[WIDTH-1:0]),
      .load_mod (shadow.mod[WIDTH-1:0]),
      .ovf      (ovf[c]),
      .tick     (ckena[c])
    );
  end

  // Shadow slot next state.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY:   if (accept && !cfg_bad) state_next = SLOT_PENDING;
      SLOT_PENDING: if (apply) state_next = SLOT_EMPTY;
      default:      state_next = SLOT_EMPTY;
    endcase
  end

  // Slot register, captured request and rejection pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= SLOT_EMPTY;
      shadow  <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      cfg_err <= accept && cfg_bad;
      if (accept && !cfg_bad) begin
        shadow.chan <= cfg_chan;
        shadow.inc  <= CFG_WIDTH'(cfg_inc);
        shadow.mod  <= CFG_WIDTH'(cfg_mod);
      end
    end
  end

endmodule

// File: tb/tb_ckdiv_ctrl.sv
module tb_ckdiv_ctrl;

  localparam int CH = 4;
  localparam int W  = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_chan;
  logic [W-1:0]  cfg_inc;
  logic [W-1:0]  cfg_mod;
  logic          cfg_err;
  logic [CH-1:0] run;
  logic          sync;
  logic          busy;
  logic [CH-1:0] ckena;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ckdiv_ctrl #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_inc   (cfg_inc),
    .cfg_mod   (cfg_mod),
    .cfg_err   (cfg_err),
    .run       (run),
    .sync      (sync),
    .busy      (busy),
    .ckena     (ckena)
  );

  // Reference: per-channel phase arithmetic and a one-entry request slot.
  longint        m_acc [CH];
  longint        m_inc [CH];
  longint        m_mod [CH];
  logic [CH-1:0] m_tick;
  logic          m_pend;
  logic          m_err;
  logic          m_rstq;
  int            m_chan;
  longint        m_sinc;
  longint        m_smod;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_inc[c] = 1;
      m_mod[c] = 1;
    end
    m_tick = '0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_rstq = 1'b0;
  endtask

  task automatic model_step();
    int     ap;
    longint s;
    logic   sy;
    logic   over;
    if (!reset) begin
      model_reset();
      return;
    end
    sy = 1'b0;
`ifdef CKDIV_CTRL_SYNC_EN
    sy = sync;
`endif
    ap = -1;
    if (m_pend && m_rstq) begin
      s = m_acc[m_chan] + m_inc[m_chan];
      if (!run[m_chan] || s >= m_mod[m_chan]) ap = m_chan;
    end
    if (m_rstq) begin
      for (int c = 0; c < CH; c++) begin
        s    = m_acc[c] + m_inc[c];
        over = run[c] && (s >= m_mod[c]);
        if (c == ap) begin
          m_inc[c]  = m_sinc;
          m_mod[c]  = m_smod;
          m_acc[c]  = 0;
          m_tick[c] = over && !sy;
        end else if (sy) begin
          m_acc[c]  = 0;
          m_tick[c] = 1'b0;
        end else if (run[c]) begin
          m_acc[c]  = over ? s - m_mod[c] : s;
          m_tick[c] = over;
        end else begin
          m_tick[c] = 1'b0;
        end
      end
    end
    m_err = 1'b0;
    if (!m_pend && cfg_valid) begin
      if (cfg_mod == 0 || cfg_inc > cfg_mod || cfg_chan >= CH) begin
        m_err = 1'b1;
      end else begin
        m_pend = 1'b1;
        m_chan = int'(cfg_chan);
        m_sinc = longint'(cfg_inc);
        m_smod = longint'(cfg_mod);
      end
    end else if (ap >= 0) begin
      m_pend = 1'b0;
    end
    m_rstq = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("outs", 32'({ckena, busy, cfg_ready, cfg_err}),
                32'({m_tick, m_pend, !m_pend, m_err}));
  endtask

  task automatic send_cfg(input int ch, input int inc, input int md);
    for (int i = 0; i < 400 && !cfg_ready; i++) step();
    chk("ready_timeout", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_chan  = 4'(ch);
    cfg_inc   = W'(inc);
    cfg_mod   = W'(md);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) step();
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, last, n, n2, n3;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_inc   = '0;
    cfg_mod   = '0;
    run       = '0;
    sync      = 1'b0;
    model_reset();
    #3;
    chk("reset_state", 32'({ckena, busy, cfg_ready, cfg_err}), 32'b0000010);

    // Defaults: inc == mod == 1, tick every cycle from the second edge.
    @(negedge clock);
    reset = 1'b1;
    run   = '1;
    step();
    chk("edge1_no_tick", 32'(ckena), 0);
    step();
    chk("edge2_tick", 32'(ckena), 32'hF);
    repeat (3) step();

    // 64/512: one tick every 8 cycles.
    send_cfg(0, 64, 512);
    wait_idle();
    chk("apply_tick0", 32'(ckena[0]), 1);
    cnt  = 0;
    last = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (ckena[0]) begin
        cnt++;
        chk("spacing8", 32'(i - last), 8);
        last = i;
      end
    end
    chk("ticks_per_64", 32'(cnt), 8);

    // Reconfigure a running channel: change lands on a tick, no runt.
    send_cfg(1, 1, 2);
    wait_idle();
    repeat (3) step();
    send_cfg(1, 1, 3);
    chk("busy_after_accept", 32'(busy), 1);
    wait_idle();
    chk("apply_tick1", 32'(ckena[1]), 1);
    n = 0;
    for (int i = 1; i <= 6 && n == 0; i++) begin
      step();
      if (ckena[1]) n = i;
    end
    chk("period3_gap", 32'(n), 3);

    // Illegal requests are swallowed with an error pulse.
    send_cfg(0, 0, 0);
    chk("err_mod0", 32'({cfg_err, busy}), 32'b10);
    send_cfg(0, 5, 4);
    chk("err_inc_gt_mod", 32'({cfg_err, busy}), 32'b10);
    send_cfg(15, 1, 4);
    chk("err_chan", 32'({cfg_err, busy}), 32'b10);
    repeat (4) step();

    // Phase alignment of two channels with different periods.
    send_cfg(2, 1, 4);
    wait_idle();
    send_cfg(3, 1, 6);
    wait_idle();
    repeat (7) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
`ifdef CKDIV_CTRL_SYNC_EN
    chk("sync_no_tick", 32'(ckena[3:2]), 0);
    n2 = 0;
    n3 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ckena[2] && n2 == 0) n2 = i;
      if (ckena[3] && n3 == 0) n3 = i;
    end
    chk("sync_gap4", 32'(n2), 4);
    chk("sync_gap6", 32'(n3), 6);
`else
    repeat (8) step();
`endif

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_chan  = 4'($urandom_range(0, 5));
      cfg_mod   = W'($urandom_range(0, 12));
      cfg_inc   = W'($urandom_range(0, 13));
      if ($urandom_range(0, 15) == 0) run = CH'($urandom);
      sync = ($urandom_range(0, 24) == 0);
      step();
    end
    cfg_valid = 1'b0;
    sync      = 1'b0;
    run       = '0;
    repeat (3) step();

    // Reset while a request is pending.
    send_cfg(0, 1, 200);
    wait_idle();
    run = '1;
    step();
    send_cfg(0, 2, 7);
    repeat (100) step();
    chk("pending_before_reset", 32'(busy), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset", 32'({ckena, busy, cfg_ready}), 32'b000001);
    model_reset();
    step();
    step();
    reset = 1'b1;
    step();
    chk("rel_edge1_no_tick", 32'(ckena), 0);
    step();
    chk("rel_edge2_tick", 32'(ckena), 32'hF);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ckdiv_ctrl.md
CKDIV_CTRL -- requirements
Module: ckdiv_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, 4, number of independent clock-enable channels (1..16).
REQ-002 SHALL have parameter WIDTH, 32, bit width of increment, modulus and accumulator.
REQ-003 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration request valid.
REQ-006 SHALL have port cfg_ready  output  1  shadow slot empty, request will be accepted.
REQ-007 SHALL have port cfg_chan  input  4  target channel index.
REQ-008 SHALL have port cfg_inc  input  WIDTH  increment (output rate numerator, DownTo).
REQ-009 SHALL have port cfg_mod  input  WIDTH  modulus (input rate denominator, From).
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse, request rejected.
REQ-011 SHALL have port run  input  CHANNELS  per-channel level enable.
REQ-012 SHALL have port sync  input  1  one-cycle phase-align pulse.
REQ-013 SHALL have port busy  output  1  config accepted but not yet applied.
REQ-014 SHALL have port ckena  output  CHANNELS  per-channel registered one-cycle tick.

Function
REQ-015 Per running channel each cycle: s = acc + inc; if s >= mod then acc <= s - mod and ckena[c] <= 1 next cycle, else acc <= s and ckena[c] <= 0.
REQ-016 s SHALL be computed WIDTH+1 bits wide; no overflow for any legal inc <= mod.
REQ-017 Tick rate SHALL be exactly f_clock*inc/mod averaged over mod cycles; inc == mod gives ckena high every cycle.
REQ-018 run[c] low: acc[c] held, ckena[c] 0 from next cycle; run[c] rising resumes from held acc.
REQ-019 Handshake: request accepted when cfg_valid && cfg_ready; cfg_ready and busy registered; cfg_ready low, busy high, from cycle after accept.
REQ-020 Request with cfg_mod == 0, cfg_inc > cfg_mod, or cfg_chan >= CHANNELS SHALL be consumed, not stored, pulse cfg_err next cycle, leave cfg_ready high.
REQ-021 Pending config on stopped channel SHALL apply the cycle after accept.
REQ-022 Pending config on running channel SHALL apply in the same cycle the channel's overflow is computed (glitch-free boundary); that tick still issues.
REQ-023 Apply: inc/mod loaded, acc cleared to 0, busy low and cfg_ready high next cycle.
REQ-024 run[c] falling while its config pending SHALL apply the following cycle per REQ-021.
REQ-025 sync SHALL clear acc of every channel to 0 in the next cycle with no tick that cycle; held (stopped) channels also cleared.
REQ-026 sync coinciding with apply: apply result used (acc 0, new inc/mod).

Reset
REQ-027 reset low SHALL asynchronously set acc 0, inc 1, mod 1, ckena 0, cfg_err 0, busy 0, cfg_ready 1, discarding any pending config.
REQ-028 Release SHALL be synchronised internally; first possible tick is the second edge after release with run high.

Configuration
REQ-029 Macro CKDIV_CTRL_SYNC_EN defined: sync functions per REQ-025/026.
REQ-030 Macro undefined: sync port remains but is ignored; no clear logic synthesised.

Structure
REQ-031 Package ckdiv_pkg SHALL hold cfg struct typedef (chan, inc, mod), defaults INC_RESET=1, MOD_RESET=1, MAX_CHANNELS=16.
REQ-032 One sub-module ckdiv_chan SHALL implement a single accumulator channel (acc, inc, mod, load, clear, tick); ckdiv_ctrl instantiates CHANNELS copies plus the shadow slot FSM (EMPTY, PENDING).

Verification
REQ-033 Reset, run=all 1, defaults -> ckena every cycle on all channels from second edge.
REQ-034 Config chan0 inc=64 mod=512, run -> exactly 8 ticks per 64 cycles, spacing 8.
REQ-035 Config chan1 inc=1 mod=3 while running with inc=1 mod=2 -> busy until next tick, then period 3, no runt tick.
REQ-036 Requests mod=0, inc=5 mod=4, chan=15 (CHANNELS=4) -> cfg_err pulse each, busy never high, state unchanged.
REQ-037 Channels inc=1 mod=4 and mod=6 out of phase, pulse sync -> both next tick 4/6 cycles after sync clear.
REQ-038 Assert reset mid-pending at cycle 100 -> busy 0, cfg_ready 1, ckena 0 immediately, defaults restored.
